// File: rtl/badder_chain_accum_pkg.sv
// -----------------------------------------------------------------------------
// badder_chain_accum_pkg
//   Shared definitions for the AP3 logic-cell carry-chain accumulator:
//   D-mux mode encodings and names, and the longest carry chain one column
//   of logic cells can host.
// -----------------------------------------------------------------------------
package badder_chain_accum_pkg;

   // Longest legal carry chain (number of chained slices).
   localparam int LC_MAX_CHAIN = 32;

   // D-mux input selection inside a slice: I0 = adder sum, I1 = load data.
   typedef enum logic {
      DMUX_I0 = 1'b0,
      DMUX_I1 = 1'b1
   } dmux_sel_e;

   // Mode strings as they appear in the architecture description.
   localparam string DMUX_I0_NAME = "I0";
   localparam string DMUX_I1_NAME = "I1";

   // Chain length is legal when it fits into one column of cells.
   function automatic bit chain_width_ok(input int width);
      return (width >= 1) && (width <= LC_MAX_CHAIN);
   endfunction

endpackage

// File: rtl/badder_chain_accum_lc_slice.sv
// -----------------------------------------------------------------------------
// badder_chain_accum_lc_slice
//   One bit of the logic-cell carry chain: full adder, 2:1 D-mux (sum or
//   load bit) and the storage flop.
// Ports
//   QCK  in  clock, rising edge
//   QRT  in  asynchronous active-high reset (flop -> 0)
//   QST  in  synchronous preset to INIT_BIT, overrides QEN and LD
//   QEN  in  clock enable
//   LD   in  select LI instead of the adder sum
//   LI   in  addend / load bit
//   CI   in  carry in from the previous slice
//   FZ   out combinational sum bit
//   CO   out combinational carry to the next slice
//   AQZ  out registered bit
// -----------------------------------------------------------------------------
module badder_chain_accum_lc_slice
   import badder_chain_accum_pkg::*;
#(
   parameter logic INIT_BIT = 1'b0
) (
   input  logic QCK,
   input  logic QRT,
   input  logic QST,
   input  logic QEN,
   input  logic LD,
   input  logic LI,
   input  logic CI,
   output logic FZ,
   output logic CO,
   output logic AQZ
);

   dmux_sel_e dmux_sel;
   logic      d_next;

   // Full adder on the registered bit and the addend.
   assign FZ = AQZ ^ LI ^ CI;
   assign CO = (AQZ & LI) | (CI & (AQZ ^ LI));

   assign dmux_sel = LD ? DMUX_I1 : DMUX_I0;
   assign d_next   = (dmux_sel == DMUX_I1) ? LI : FZ;

   always_ff @(posedge QCK or posedge QRT) begin
      if (QRT) begin
         AQZ <= 1'b0;
      end else if (QST) begin
         AQZ <= INIT_BIT;
      end else if (QEN) begin
         AQZ <= d_next;
      end
   end

endmodule

// File: rtl/badder_chain_accum.sv
// -----------------------------------------------------------------------------
// badder_chain_accum
//   Registered WIDTH-bit accumulator/counter built from chained per-bit
//   adder+FF slices. Carry ripples CI -> slice 0 -> ... -> slice WIDTH-1 -> CO.
//   A sticky OVF flop records any carry-out taken into the register.
// Parameters
//   WIDTH  number of slices (1..LC_MAX_CHAIN)
//   INIT   value loaded by QST
// Ports
//   QCK  in  clock, rising edge
//   QRT  in  asynchronous active-high reset (AQZ=0, OVF=0)
//   QST  in  synchronous preset to INIT, clears OVF; ignores QEN and LD
//   QEN  in  clock enable for AQZ and OVF
//   LD   in  load LI instead of the sum; clears OVF
//   LI   in  addend / load data
//   CI   in  carry into slice 0
//   FZ   out combinational AQZ+LI+CI, low WIDTH bits
//   CO   out combinational carry out of the top slice
//   AQZ  out registered accumulator
//   OVF  out registered sticky carry-out flag
// -----------------------------------------------------------------------------
module badder_chain_accum
   import badder_chain_accum_pkg::*;
#(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] INIT  = '0
) (
   input  logic             QCK,
   input  logic             QRT,
   input  logic             QST,
   input  logic             QEN,
   input  logic             LD,
   input  logic [WIDTH-1:0] LI,
   input  logic             CI,
   output logic [WIDTH-1:0] FZ,
   output logic             CO,
   output logic [WIDTH-1:0] AQZ,
   output logic             OVF
);

   if (!chain_width_ok(WIDTH)) begin : g_width_check
      $error("badder_chain_accum: WIDTH=%0d outside 1..%0d", WIDTH, LC_MAX_CHAIN);
   end

   // carry[0] is the chain input, carry[WIDTH] leaves the top slice.
   logic [WIDTH:0] carry;

   assign carry[0] = CI;
   assign CO       = carry[WIDTH];

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_slice
      badder_chain_accum_lc_slice #(
         .INIT_BIT (INIT[gi])
      ) u_slice (
         .QCK (QCK),
         .QRT (QRT),
         .QST (QST),
         .QEN (QEN),
         .LD  (LD),
         .LI  (LI[gi]),
         .CI  (carry[gi]),
         .FZ  (FZ[gi]),
         .CO  (carry[gi+1]),
         .AQZ (AQZ[gi])
      );
   end

   // Sticky overflow follows the same priority as the slice flops, so it is
   // only set by an edge that actually stores the sum.
   always_ff @(posedge QCK or posedge QRT) begin
      if (QRT) begin
         OVF <= 1'b0;
      end else if (QST) begin
         OVF <= 1'b0;
      end else if (QEN) begin
         if (LD) begin
            OVF <= 1'b0;
         end else begin
            OVF <= OVF | CO;
         end
      end
   end

endmodule

// File: tb/tb_badder_chain_accum.sv
// -----------------------------------------------------------------------------
// tb_badder_chain_accum
//   Directed bench for badder_chain_accum with WIDTH=8, INIT=8'hA5.
// -----------------------------------------------------------------------------
module tb_badder_chain_accum;

   logic       QCK = 1'b0;
   logic       QRT = 1'b1;
   logic       QST = 1'b0;
   logic       QEN = 1'b0;
   logic       LD  = 1'b0;
   logic [7:0] LI  = 8'h00;
   logic       CI  = 1'b0;
   logic [7:0] FZ;
   logic       CO;
   logic [7:0] AQZ;
   logic       OVF;

   int n_checks = 0;
   int n_fail   = 0;

   badder_chain_accum #(
      .WIDTH (8),
      .INIT  (8'hA5)
   ) dut (
      .QCK (QCK),
      .QRT (QRT),
      .QST (QST),
      .QEN (QEN),
      .LD  (LD),
      .LI  (LI),
      .CI  (CI),
      .FZ  (FZ),
      .CO  (CO),
      .AQZ (AQZ),
      .OVF (OVF)
   );

   always #5 QCK = ~QCK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Advance past the next rising edge and settle away from it.
   task automatic tick();
      @(posedge QCK);
      #1;
   endtask

   initial begin
      // Reset state
      #2;
      check("rst_aqz", {24'd0, AQZ}, 32'h00);
      check("rst_ovf", {31'd0, OVF}, 32'h0);
      tick();
      QRT = 1'b0;
      tick();

      // Build AQZ=37, OVF=1: load 38, then add FF (0x38+0xFF = 0x137)
      QEN = 1'b1; LD = 1'b1; LI = 8'h38; CI = 1'b0;
      tick();
      check("pre_load38", {24'd0, AQZ}, 32'h38);
      LD = 1'b0; LI = 8'hFF;
      #1;
      check("pre_fz", {23'd0, CO, FZ}, 32'h137);
      tick();
      check("pre_aqz37", {24'd0, AQZ}, 32'h37);
      check("pre_ovf1", {31'd0, OVF}, 32'h1);

      // 1. Reset mid-count, between edges
      #2;
      QRT = 1'b1;
      #1;
      check("t1_async_aqz", {24'd0, AQZ}, 32'h00);
      check("t1_async_ovf", {31'd0, OVF}, 32'h0);
      LD = 1'b1; LI = 8'h55;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t1_hold_aqz", {24'd0, AQZ}, 32'h00);
         check("t1_hold_ovf", {31'd0, OVF}, 32'h0);
      end
      #2;
      QRT = 1'b0;

      // 2. Load
      LD = 1'b1; QEN = 1'b1; LI = 8'h5A;
      tick();
      check("t2_load_aqz", {24'd0, AQZ}, 32'h5A);
      check("t2_load_ovf", {31'd0, OVF}, 32'h0);

      // 3. Accumulate with carry
      LI = 8'hF0;
      tick();
      check("t3_start", {24'd0, AQZ}, 32'hF0);
      LD = 1'b0; LI = 8'h0F; CI = 1'b1;
      #1;
      check("t3_fz", {24'd0, FZ}, 32'h00);
      check("t3_co", {31'd0, CO}, 32'h1);
      tick();
      check("t3_aqz", {24'd0, AQZ}, 32'h00);
      check("t3_ovf", {31'd0, OVF}, 32'h1);

      // 4. Hold with QEN=0
      QEN = 1'b0; LI = 8'h01; CI = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t4_aqz", {24'd0, AQZ}, 32'h00);
         check("t4_ovf", {31'd0, OVF}, 32'h1);
         check("t4_fz", {23'd0, CO, FZ}, 32'h002);
      end
      LD = 1'bx; LI = 8'hxx; CI = 1'bx;
      tick();
      check("t4_x_aqz", {24'd0, AQZ}, 32'h00);
      check("t4_x_ovf", {31'd0, OVF}, 32'h1);

      // 5. Priority: QST beats QEN=0 and LD=1
      QST = 1'b1; LD = 1'b1; QEN = 1'b0; LI = 8'h3C; CI = 1'b0;
      tick();
      check("t5_aqz", {24'd0, AQZ}, 32'hA5);
      check("t5_ovf", {31'd0, OVF}, 32'h0);
      QST = 1'b0;

      // 6. Increment wrap
      QEN = 1'b1; LD = 1'b1; LI = 8'hFE;
      tick();
      check("t6_start", {24'd0, AQZ}, 32'hFE);
      LD = 1'b0; LI = 8'h00; CI = 1'b1;
      tick();
      check("t6_ff", {24'd0, AQZ}, 32'hFF);
      check("t6_ff_ovf", {31'd0, OVF}, 32'h0);
      tick();
      check("t6_00", {24'd0, AQZ}, 32'h00);
      check("t6_00_ovf", {31'd0, OVF}, 32'h1);
      tick();
      check("t6_01", {24'd0, AQZ}, 32'h01);
      check("t6_01_ovf", {31'd0, OVF}, 32'h1);

      // Decrementer: 01 + FF -> 00, then 00 + FF -> FF
      LI = 8'hFF; CI = 1'b0;
      tick();
      check("dec_00", {24'd0, AQZ}, 32'h00);
      tick();
      check("dec_ff", {24'd0, AQZ}, 32'hFF);
      check("dec_ovf", {31'd0, OVF}, 32'h1);

      // LD clears the sticky flag
      LD = 1'b1; LI = 8'h12;
      tick();
      check("ld_clr_aqz", {24'd0, AQZ}, 32'h12);
      check("ld_clr_ovf", {31'd0, OVF}, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
